// File: rtl/iir_biquad_cascade.sv
// iir_biquad_cascade: N_STAGES x N_CH direct-form-I biquad cascade on one shared MAC; clk, i_rst_n (async low), i_clear, i_valid/o_ready/i_sample frame in, o_valid/o_sample frame out, i_coef_we/i_coef_addr/i_coef_data coefficient write, o_coef_err dropped-write pulse
module iir_biquad_cascade #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int FRAC = 16,
  parameter int N_STAGES = 4,
  parameter int N_CH = 2
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [N_CH*DATA_W-1:0]   i_sample,
  output logic                     o_valid,
  output logic [N_CH*DATA_W-1:0]   o_sample,
  input  logic                     i_coef_we,
  input  logic [5:0]               i_coef_addr,
  input  logic [COEF_W-1:0]        i_coef_data,
  output logic                     o_coef_err
);
  localparam int PW = DATA_W + COEF_W;
  localparam int AW = PW + 3;
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int SW = N_STAGES > 1 ? $clog2(N_STAGES) : 1;
  localparam int NC = 5 * N_STAGES;
  localparam int IW = $clog2(NC);
  localparam logic signed [AW-1:0] HALF = AW'(1) << (FRAC - 1);
  localparam logic signed [AW-1:0] MAXV = AW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;
  typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] ch;
  logic [SW-1:0] stg;
  logic [2:0] tap;
  logic [IW-1:0] cidx;
  logic [N_CH*DATA_W-1:0] in_lat, out_buf;
  logic signed [DATA_W-1:0] cur, op, y;
  logic signed [DATA_W-1:0] x1 [N_CH][N_STAGES];
  logic signed [DATA_W-1:0] x2 [N_CH][N_STAGES];
  logic signed [DATA_W-1:0] y1 [N_CH][N_STAGES];
  logic signed [DATA_W-1:0] y2 [N_CH][N_STAGES];
  logic signed [COEF_W-1:0] coef [NC];
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc, acc_nx, rnd;
  logic last_stg, last_ch;

  assign o_ready = state == IDLE || state == DONE;
  assign last_stg = stg == SW'(N_STAGES - 1);
  assign last_ch = ch == CW'(N_CH - 1);
  assign cidx = IW'(int'(stg) * 5 + int'(tap));

  always_comb begin
    op = tap == 3'd0 ? cur : tap == 3'd1 ? x1[ch][stg] : tap == 3'd2 ? x2[ch][stg] : tap == 3'd3 ? y1[ch][stg] : y2[ch][stg];
    prod = coef[cidx] * op;
    acc_nx = tap < 3'd3 ? acc + AW'(prod) : acc - AW'(prod);
    rnd = (acc + HALF) >>> FRAC;
    y = rnd > MAXV ? MAXV[DATA_W-1:0] : rnd < MINV ? MINV[DATA_W-1:0] : rnd[DATA_W-1:0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = i_valid ? MAC : IDLE;
      MAC: state_nx = tap == 3'd4 ? WB : MAC;
      WB: state_nx = last_stg && last_ch ? DONE : MAC;
      default: state_nx = IDLE;
    endcase
    if (i_clear) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;

  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int i = 0; i < NC; i++) coef[i] <= i % 5 == 0 ? COEF_W'(2 ** FRAC) : '0;
      o_coef_err <= 1'b0;
    end else begin
      o_coef_err <= i_coef_we && (!o_ready || int'(i_coef_addr) >= NC);
      if (i_coef_we && o_ready && int'(i_coef_addr) < NC) coef[IW'(i_coef_addr)] <= i_coef_data;
    end

  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int c = 0; c < N_CH; c++)
        for (int s = 0; s < N_STAGES; s++) begin
          x1[c][s] <= '0;
          x2[c][s] <= '0;
          y1[c][s] <= '0;
          y2[c][s] <= '0;
        end
      acc <= '0;
      tap <= '0;
      ch <= '0;
      stg <= '0;
      cur <= '0;
      in_lat <= '0;
      out_buf <= '0;
      o_sample <= '0;
      o_valid <= 1'b0;
    end else if (i_clear) begin
      for (int c = 0; c < N_CH; c++)
        for (int s = 0; s < N_STAGES; s++) begin
          x1[c][s] <= '0;
          x2[c][s] <= '0;
          y1[c][s] <= '0;
          y2[c][s] <= '0;
        end
      acc <= '0;
      tap <= '0;
      ch <= '0;
      stg <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= state == DONE;
      if (state == DONE) o_sample <= out_buf;
      if (state == MAC) begin
        acc <= acc_nx;
        tap <= tap + 3'd1;
      end
      if (state == WB) begin
        x2[ch][stg] <= x1[ch][stg];
        x1[ch][stg] <= cur;
        y2[ch][stg] <= y1[ch][stg];
        y1[ch][stg] <= y;
        acc <= '0;
        tap <= '0;
        stg <= last_stg ? '0 : stg + 1'b1;
        ch <= last_stg ? ch + 1'b1 : ch;
        cur <= last_stg ? DATA_W'(in_lat >> DATA_W) : y;
        if (last_stg) begin
          in_lat <= in_lat >> DATA_W;
          out_buf <= (N_CH*DATA_W)'({y, out_buf} >> DATA_W);
        end
      end
      if (o_ready && i_valid) begin
        in_lat <= i_sample;
        cur <= i_sample[DATA_W-1:0];
        ch <= '0;
      end
    end
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// tb_iir_biquad_cascade: directed vector and sequence checks of iir_biquad_cascade with default parameters
module tb_iir_biquad_cascade;
  logic clk = 0, rst_n = 0, clear = 0, valid = 0, ready, ovalid, we = 0, err, e;
  logic [31:0] sample = '0, osample;
  logic [5:0] addr = '0;
  logic [17:0] data = '0;
  int nvec = 0, nmis = 0, nv, na, cyc, lat;
  int acc_t[4];
  typedef struct {logic [17:0] b0; int x0, x1, e0, e1;} vec_t;
  vec_t tv[4];

  iir_biquad_cascade dut (
    .clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_valid(valid), .o_ready(ready),
    .i_sample(sample), .o_valid(ovalid), .o_sample(osample), .i_coef_we(we),
    .i_coef_addr(addr), .i_coef_data(data), .o_coef_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ch(input int c);
    return int'($signed(osample[c*16 +: 16]));
  endfunction

  task automatic wcoef(input int a, input logic [17:0] d, output logic ev);
    @(negedge clk);
    we = 1;
    addr = 6'(a);
    data = d;
    @(negedge clk);
    we = 0;
    ev = err;
  endtask

  task automatic clr();
    @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
  endtask

  task automatic send(input int a, input int b);
    @(negedge clk);
    sample = {16'(b), 16'(a)};
    valid = 1;
    @(negedge clk);
    valid = 0;
  endtask

  task automatic await(inout int l);
    while (!ovalid && l < 200) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic frame(input string nm, input int a, input int b, input int ea, input int eb);
    int l = 0;
    send(a, b);
    await(l);
    chk({nm, "_lat"}, l, 49);
    chk({nm, "_ch0"}, ch(0), ea);
    chk({nm, "_ch1"}, ch(1), eb);
  endtask

  initial begin
    tv[0] = '{18'h08000, 3, -3, 2, -1};
    tv[1] = '{18'h1FFFF, 20000, -20000, 32767, -32768};
    tv[2] = '{18'h30000, 1234, -32768, -1234, 32767};
    tv[3] = '{18'h08000, 1, -1, 1, 0};
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_valid", ovalid, 0);
    chk("rst_sample", int'(osample), 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1;
    frame("pass", 1000, -2000, 1000, -2000);
    @(negedge clk);
    chk("valid_pulse", ovalid, 0);
    chk("sample_held", ch(0), 1000);
    for (int i = 0; i < 4; i++) begin
      wcoef(0, tv[i].b0, e);
      chk($sformatf("tbl%0d_err", i), e, 0);
      clr();
      frame($sformatf("tbl%0d", i), tv[i].x0, tv[i].x1, tv[i].e0, tv[i].e1);
    end
    wcoef(0, 18'h10000, e);
    wcoef(3, 18'h38000, e);
    chk("pole_err", e, 0);
    clr();
    for (int k = 0; k < 4; k++) frame($sformatf("rec%0d", k), k == 0 ? 1024 : 0, 0, 1024 >> k, 0);
    send(1024, 0);
    repeat (9) @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    chk("clr_ready", ready, 1);
    nv = 0;
    repeat (60) begin
      @(negedge clk);
      if (ovalid) nv++;
    end
    chk("clr_no_valid", nv, 0);
    chk("clr_held", ch(0), 128);
    frame("clr_zero", 0, 0, 0, 0);
    frame("clr_imp", 1024, 0, 1024, 0);
    frame("clr_dec", 0, 0, 512, 0);
    @(negedge clk);
    clear = 1;
    valid = 1;
    sample = {16'd0, 16'd77};
    @(negedge clk);
    clear = 0;
    valid = 0;
    chk("clr_wins_ready", ready, 1);
    wcoef(3, 18'h0, e);
    chk("a1_zero_err", e, 0);
    clr();
    send(100, 0);
    @(negedge clk);
    we = 1;
    addr = 6'd0;
    data = 18'h08000;
    @(negedge clk);
    we = 0;
    chk("busy_err", err, 1);
    @(negedge clk);
    chk("busy_err_pulse", err, 0);
    lat = 3;
    await(lat);
    chk("busy_lat", lat, 49);
    chk("busy_ch0", ch(0), 100);
    frame("after_busy", 200, 0, 200, 0);
    wcoef(20, 18'h1, e);
    chk("bad_addr_err", e, 1);
    wcoef(19, 18'h0, e);
    chk("last_addr_err", e, 0);
    @(negedge clk);
    nv = 0;
    na = 0;
    cyc = 0;
    valid = 1;
    while (na < 4 && cyc < 400) begin
      if (ovalid) begin
        chk($sformatf("b2b_out%0d", nv), ch(0), 100 * (nv + 1));
        nv++;
      end
      if (ready) begin
        sample = {16'(-(na + 1)), 16'(100 * (na + 1))};
        acc_t[na] = cyc;
        na++;
      end
      @(negedge clk);
      cyc++;
    end
    valid = 0;
    chk("b2b_accepts", na, 4);
    repeat (60) begin
      if (ovalid) begin
        chk($sformatf("b2b_out%0d", nv), ch(0), 100 * (nv + 1));
        nv++;
      end
      @(negedge clk);
    end
    chk("b2b_valids", nv, 4);
    for (int i = 1; i < 4; i++) chk($sformatf("b2b_gap%0d", i), acc_t[i] - acc_t[i-1], 49);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
